dn_rom_router: RTL and testbench

Routes the HPS ROM download stream into the Scramble core's ROM regions and owns the core reset sequencing around a download. It sits between hps_io's ioctl outputs and scramble_top's dn_addr/dn_data/dn_wr/RESET inputs. It registers each accepted byte, decodes it to a per-region write enable, and keeps a byte count and an additive checksum. It holds the core in reset until a complete image has loaded and a settle interval has elapsed.

---
 rtl/dn_rom_router.sv | 91 +++++++++
 tb/tb_dn_rom_router.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dn_rom_router.sv
// dn_rom_router: steers the HPS ROM download into Scramble ROM regions and sequences core reset around it.
module dn_rom_router #(
    parameter logic [15:0] IMAGE_SIZE  = 16'h6820,
    parameter int          HOLD_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        prg_we,
    output logic        snd_we,
    output logic        gfx_we,
    output logic        prom_we,
    output logic        core_reset,
    output logic        rom_ok,
    output logic [15:0] checksum
);
    localparam int HW = HOLD_CYCLES > 0 ? $clog2(HOLD_CYCLES + 1) : 1;
    typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;
    state_t        state;
    logic          blocked;
    logic [16:0]   count;
    logic [HW-1:0] hold_cnt;
    logic          dl, acc, prg, snd, gfx, prom;
    logic [15:0]   a;
    // A download interrupted by RESET stays ignored until its level drops.
    assign dl   = ioctl_download & ~blocked;
    assign acc  = ioctl_wr & dl & (ioctl_addr < {9'd0, IMAGE_SIZE});
    assign a    = ioctl_addr[15:0];
    assign prg  = a < 16'h4000;
    assign snd  = a >= 16'h4000 && a < 16'h5800;
    assign gfx  = a >= 16'h5800 && a < 16'h6800;
    assign prom = a >= 16'h6800 && a < 16'h6820;
    always_ff @(posedge clk) begin
        if (RESET) begin
            state      <= IDLE;
            blocked    <= ioctl_download;
            count      <= '0;
            hold_cnt   <= '0;
            dn_addr    <= '0;
            dn_data    <= '0;
            dn_wr      <= 1'b0;
            prg_we     <= 1'b0;
            snd_we     <= 1'b0;
            gfx_we     <= 1'b0;
            prom_we    <= 1'b0;
            core_reset <= 1'b1;
            rom_ok     <= 1'b0;
            checksum   <= '0;
        end else begin
            if (!ioctl_download) blocked <= 1'b0;
            dn_wr   <= acc;
            prg_we  <= acc & prg;
            snd_we  <= acc & snd;
            gfx_we  <= acc & gfx;
            prom_we <= acc & prom;
            if (acc) begin
                dn_addr <= a;
                dn_data <= ioctl_dout;
            end
            if (state != LOAD && dl) begin
                state      <= LOAD;
                core_reset <= 1'b1;
                count      <= {16'd0, acc};
                checksum   <= acc ? {8'd0, ioctl_dout} : 16'd0;
            end else if (state == LOAD) begin
                if (acc) begin
                    count    <= count != '1 ? count + 17'd1 : count;
                    checksum <= checksum + {8'd0, ioctl_dout};
                end
                if (!dl) begin
                    state    <= HOLD;
                    rom_ok   <= count == {1'b0, IMAGE_SIZE};
                    hold_cnt <= HW'(HOLD_CYCLES);
                end
            end else if (state == HOLD) begin
                if (hold_cnt == '0) begin
                    state      <= rom_ok ? RUN : IDLE;
                    core_reset <= ~rom_ok;
                end else begin
                    hold_cnt <= hold_cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dn_rom_router.sv
// tb_dn_rom_router: scoreboard bench for the ROM download router and its reset sequencing.
module tb_dn_rom_router;
    logic        clk = 1'b0, RESET = 1'b1, ioctl_download = 1'b0, ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [15:0] dn_addr, checksum;
    logic [7:0]  dn_data;
    logic        dn_wr, prg_we, snd_we, gfx_we, prom_we, core_reset, rom_ok;
    int          n_checks = 0, n_errors = 0;
    int          n_wr = 0, n_prg = 0, n_snd = 0, n_gfx = 0, n_prom = 0;
    int          fall;
    logic [27:0] q[$];
    logic [27:0] e;
    logic [15:0] exp_sum;
    always #5 clk = ~clk;
    dn_rom_router #(.IMAGE_SIZE(16'h6820), .HOLD_CYCLES(16)) dut (
        .clk(clk), .RESET(RESET), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .dn_addr(dn_addr), .dn_data(dn_data),
        .dn_wr(dn_wr), .prg_we(prg_we), .snd_we(snd_we), .gfx_we(gfx_we), .prom_we(prom_we),
        .core_reset(core_reset), .rom_ok(rom_ok), .checksum(checksum)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [3:0] region(input int a);
        logic [3:0] r;
        r[3] = a < 'h4000;
        r[2] = a >= 'h4000 && a < 'h5800;
        r[1] = a >= 'h5800 && a < 'h6800;
        r[0] = a >= 'h6800 && a < 'h6820;
        return r;
    endfunction
    always @(negedge clk) begin
        n_prg  += int'(prg_we);
        n_snd  += int'(snd_we);
        n_gfx  += int'(gfx_we);
        n_prom += int'(prom_we);
        if (dn_wr) begin
            n_wr++;
            if (q.size() == 0) chk("unexp_wr", 1, 0);
            else begin
                e = q.pop_front();
                chk("wr_beat", {dn_addr, dn_data, prg_we, snd_we, gfx_we, prom_we}, e);
            end
        end
    end
    task automatic clr();
        n_wr = 0; n_prg = 0; n_snd = 0; n_gfx = 0; n_prom = 0;
    endtask
    task automatic stream(input int n, input logic [7:0] key, input bit drop);
        logic [7:0] d;
        exp_sum = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            d = 8'(i) ^ key;
            ioctl_download = 1'b1; ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = d;
            if (i < 'h6820) begin
                q.push_back({16'(i), d, region(i)});
                exp_sum += {8'd0, d};
            end
            if (i == 1) begin
                @(negedge clk);
                chk("rst_rise", core_reset, 1);
            end
        end
        if (drop) begin
            @(posedge clk); #1;
            ioctl_wr = 1'b0; ioctl_download = 1'b0;
        end
    endtask
    task automatic settle(output int f);
        f = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (!core_reset && f < 0) f = k;
        end
    endtask
    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_addr", dn_addr, 0);
        chk("rst_data", dn_data, 0);
        chk("rst_wr", dn_wr, 0);
        chk("rst_core", core_reset, 1);
        chk("rst_ok", rom_ok, 0);
        chk("rst_sum", checksum, 0);
        @(posedge clk); #1 RESET = 1'b0;
        repeat (20) @(negedge clk);
        chk("pwr_core", core_reset, 1);
        chk("pwr_ok", rom_ok, 0);
        chk("pwr_wr", n_wr, 0);
        clr();
        stream('h6820, 8'h00, 1'b1);
        settle(fall);
        chk("full_fall", fall, 18);
        chk("full_ok", rom_ok, 1);
        chk("full_sum", checksum, exp_sum);
        chk("full_prg", n_prg, 16384);
        chk("full_snd", n_snd, 6144);
        chk("full_gfx", n_gfx, 4096);
        chk("full_prom", n_prom, 32);
        chk("full_wr", n_wr, 'h6820);
        chk("full_q", q.size(), 0);
        clr();
        stream('h800, 8'h3C, 1'b1);
        settle(fall);
        chk("short_fall", fall, -1);
        chk("short_ok", rom_ok, 0);
        chk("short_core", core_reset, 1);
        chk("short_sum", checksum, exp_sum);
        chk("short_wr", n_wr, 'h800);
        clr();
        stream('h8000, 8'h5A, 1'b1);
        settle(fall);
        chk("over_wr", n_wr, 'h6820);
        chk("over_ok", rom_ok, 1);
        chk("over_fall", fall, 18);
        chk("over_sum", checksum, exp_sum);
        chk("over_q", q.size(), 0);
        clr();
        stream(3, 8'hA5, 1'b0);
        @(negedge clk);
        chk("restart_okhold", rom_ok, 1);
        @(posedge clk); #1;
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        settle(fall);
        chk("restart_sum", checksum, exp_sum);
        chk("restart_ok", rom_ok, 0);
        chk("restart_fall", fall, -1);
        chk("restart_wr", n_wr, 3);
        clr();
        stream(100, 8'h11, 1'b0);
        @(posedge clk); #1;
        RESET = 1'b1; ioctl_addr = 25'd100;
        @(posedge clk); #1;
        chk("mid_addr", dn_addr, 0);
        chk("mid_data", dn_data, 0);
        chk("mid_wr", dn_wr, 0);
        chk("mid_we", {prg_we, snd_we, gfx_we, prom_we}, 0);
        chk("mid_core", core_reset, 1);
        chk("mid_ok", rom_ok, 0);
        chk("mid_sum", checksum, 0);
        RESET = 1'b0;
        repeat (20) begin
            @(posedge clk); #1 ioctl_addr = ioctl_addr + 25'd1;
        end
        chk("mid_ignored", n_wr, 100);
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        repeat (3) @(posedge clk);
        clr();
        stream(50, 8'h77, 1'b1);
        settle(fall);
        chk("post_wr", n_wr, 50);
        chk("post_sum", checksum, exp_sum);
        chk("post_ok", rom_ok, 0);
        chk("post_q", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
